// File: rtl/hamming_argmin_if.sv
// Handshake bundle between the hamming distance core stream and the argmin result consumer.
interface hamming_argmin_if #(
  parameter int N = 8,
  parameter int K = 16
);
  function automatic int log2(input int v);
    return $clog2(v + 1);
  endfunction

  localparam int DW = log2(N);
  localparam int IW = log2(K);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dist;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_min;
  logic [IW-1:0] out_idx;
  logic          out_ovf;

  modport slave (
    input  in_valid, in_dist, in_last, out_ready,
    output in_ready, out_valid, out_min, out_idx, out_ovf
  );

  modport master (
    output in_valid, in_dist, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_idx, out_ovf
  );
endinterface

// File: rtl/hamming_argmin.sv
// Tracks the minimum distance and its first index over a search of up to K candidates,
// then holds the winner behind a valid/ready handshake.
module hamming_argmin #(
  parameter int N = 8,
  parameter int K = 16
) (
  input  logic             clk,
  input  logic             rst,
  hamming_argmin_if.slave  bus
);
  function automatic int log2(input int v);
    return $clog2(v + 1);
  endfunction

  localparam int DW = log2(N);
  localparam int IW = log2(K);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [IW:0] CNT_LAST = (IW+1)'(K - 1);

  logic [1:0]    state_q,  state_d;
  logic [IW:0]   cnt_q,    cnt_d;
  logic [DW-1:0] best_q,   best_d;
  logic [IW-1:0] bidx_q,   bidx_d;
  logic          ovalid_q, ovalid_d;
  logic [DW-1:0] omin_q,   omin_d;
  logic [IW-1:0] oidx_q,   oidx_d;
  logic          oovf_q,   oovf_d;
  logic          acc, close;

  // Ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = (state_q != S_DONE);
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ovalid_q;
  assign bus.out_min   = omin_q;
  assign bus.out_idx   = oidx_q;
  assign bus.out_ovf   = oovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    best_d   = best_q;
    bidx_d   = bidx_q;
    ovalid_d = ovalid_q;
    omin_d   = omin_q;
    oidx_d   = oidx_q;
    oovf_d   = oovf_q;
    close    = 1'b0;
    case (state_q)
      S_IDLE: if (acc) begin
        best_d  = bus.in_dist;
        bidx_d  = '0;
        cnt_d   = (IW+1)'(1);
        close   = bus.in_last || (K == 1);
        state_d = close ? S_DONE : S_SEARCH;
      end
      S_SEARCH: if (acc) begin
        // Strict compare: ties keep the earlier index.
        if (bus.in_dist < best_q) begin
          best_d = bus.in_dist;
          bidx_d = cnt_q[IW-1:0];
        end
        cnt_d = cnt_q + 1'b1;
        close = bus.in_last || (cnt_q == CNT_LAST);
        if (close) state_d = S_DONE;
      end
      S_DONE: if (bus.out_ready) begin
        ovalid_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Result takes the closing candidate's update in the same cycle.
    if (close) begin
      ovalid_d = 1'b1;
      omin_d   = best_d;
      oidx_d   = bidx_d;
      oovf_d   = ~bus.in_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      best_q   <= '0;
      bidx_q   <= '0;
      ovalid_q <= 1'b0;
      omin_q   <= '0;
      oidx_q   <= '0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      best_q   <= best_d;
      bidx_q   <= bidx_d;
      ovalid_q <= ovalid_d;
      omin_q   <= omin_d;
      oidx_q   <= oidx_d;
      oovf_q   <= oovf_d;
    end
  end
endmodule

// File: tb/tb_hamming_argmin.sv
// Scoreboard bench for hamming_argmin: expected winners are queued as searches are driven
// and popped when the result appears.
module tb_hamming_argmin;
  localparam int N  = 8;
  localparam int K  = 16;
  localparam int DW = $clog2(N + 1);
  localparam int IW = $clog2(K + 1);

  typedef struct packed {
    logic [DW-1:0] mn;
    logic [IW-1:0] idx;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  int   vals[0:K-1];

  hamming_argmin_if #(.N(N), .K(K)) bus ();
  hamming_argmin #(.N(N), .K(K)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: strict-less scan over vals[0..len-1].
  function automatic exp_t model(input int len, input bit ovf);
    exp_t e;
    int   m, mi;
    m = vals[0]; mi = 0;
    for (int i = 1; i < len; i++) if (vals[i] < m) begin m = vals[i]; mi = i; end
    e.mn = DW'(m); e.idx = IW'(mi); e.ovf = ovf;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int d, input bit l);
    int n;
    bus.in_valid = 1'b1; bus.in_dist = DW'(d); bus.in_last = l;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic check_result(input string nm, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL %s_valid: got %b required 1", nm, bus.out_valid);
    end
    if (exp_q.size() == 0) begin
      tests_failed++; $display("FAIL %s_scoreboard: expectation queue empty", nm);
      return;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (bus.out_min !== e.mn || bus.out_idx !== e.idx || bus.out_ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL %s_result: got min=%0d idx=%0d ovf=%b required min=%0d idx=%0d ovf=%b",
               nm, bus.out_min, bus.out_idx, bus.out_ovf, e.mn, e.idx, e.ovf);
    end
    repeat (hold) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_min !== e.mn ||
          bus.out_idx !== e.idx || bus.out_ovf !== e.ovf) begin
        tests_failed++;
        $display("FAIL %s_hold: got v=%b rdy=%b min=%0d idx=%0d required v=1 rdy=0 min=%0d idx=%0d",
                 nm, bus.out_valid, bus.in_ready, bus.out_min, bus.out_idx, e.mn, e.idx);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_min !== e.mn ||
        bus.out_idx !== e.idx || bus.out_ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL %s_handoff: got v=%b rdy=%b min=%0d idx=%0d required v=0 rdy=1 min=%0d idx=%0d",
               nm, bus.out_valid, bus.in_ready, bus.out_min, bus.out_idx, e.mn, e.idx);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_dist = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_min !== '0 || bus.out_idx !== '0 || bus.out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b min=%0d idx=%0d ovf=%b required all 0",
               bus.out_valid, bus.out_min, bus.out_idx, bus.out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    vals[0] = 5; vals[1] = 3; vals[2] = 7; vals[3] = 3;
    exp_q.push_back(model(4, 1'b0));
    for (int i = 0; i < 4; i++) send(vals[i], i == 3);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL basic_latency: out_valid got %b required 1", bus.out_valid);
    end
    check_result("basic", 0);
  endtask

  task automatic test_single();
    vals[0] = 6;
    exp_q.push_back(model(1, 1'b0));
    send(6, 1'b1);
    check_result("single", 3);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < K; i++) vals[i] = 8;
    exp_q.push_back(model(K, 1'b1));
    for (int i = 0; i < K - 1; i++) send(8, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_early: out_valid got %b required 0 after %0d", bus.out_valid, K-1);
    end
    send(8, 1'b0);
    // A 17th candidate must be refused while the result is pending.
    bus.in_valid = 1'b1; bus.in_dist = '0; bus.in_last = 1'b1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_extra_ready: got %b required 0", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check_result("overflow", 0);
  endtask

  task automatic test_backpressure();
    vals[0] = 2; vals[1] = 1;
    exp_q.push_back(model(2, 1'b0));
    send(2, 1'b0); send(1, 1'b1);
    bus.in_valid = 1'b1; bus.in_dist = '0; bus.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_min !== DW'(1) || bus.out_idx !== IW'(1)) begin
        tests_failed++;
        $display("FAIL bp_stall: got rdy=%b v=%b min=%0d idx=%0d required rdy=0 v=1 min=1 idx=1",
                 bus.in_ready, bus.out_valid, bus.out_min, bus.out_idx);
      end
    end
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_handoff_ready: got %b required 0", bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    // Candidate 0/last has been held valid throughout; it is taken now.
    vals[0] = 0;
    exp_q.push_back(model(1, 1'b0));
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_idle: got rdy=%b v=%b required rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_next_accept: out_valid got %b required 1", bus.out_valid);
    end
    check_result("bp_next", 0);
  endtask

  task automatic test_gaps();
    vals[0] = 4; vals[1] = 2; vals[2] = 0; vals[3] = 1;
    exp_q.push_back(model(4, 1'b0));
    send(4, 1'b0);
    repeat (3) @(negedge clk);
    send(2, 1'b0);
    @(negedge clk);
    send(0, 1'b0);
    send(1, 1'b1);
    check_result("gaps", 1);
  endtask

  task automatic test_reset_mid();
    send(2, 1'b0); send(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_min !== '0 || bus.out_idx !== '0 || bus.out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got v=%b min=%0d idx=%0d ovf=%b required all 0",
               bus.out_valid, bus.out_min, bus.out_idx, bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_ready: got %b required 1", bus.in_ready);
    end
    vals[0] = 7;
    exp_q.push_back(model(1, 1'b0));
    send(7, 1'b1);
    check_result("midreset_new", 0);
    vals[0] = 3; vals[1] = 5; vals[2] = 1;
    exp_q.push_back(model(3, 1'b0));
    for (int i = 0; i < 3; i++) send(vals[i], i == 2);
    check_result("midreset_idx", 0);
  endtask

  task automatic test_back_to_back();
    int len;
    bit use_last;
    for (int s = 0; s < 8; s++) begin
      len = (s == 0) ? K : int'($urandom_range(1, K));
      use_last = (len < K) ? 1'b1 : 1'(s % 2);
      for (int i = 0; i < len; i++) vals[i] = int'($urandom_range(0, N));
      exp_q.push_back(model(len, !use_last));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(vals[i], use_last && (i == len - 1));
      end
      check_result("random", int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/hamming_argmin.md
Name: hamming_argmin

Overview:
- Sits directly downstream of the hamming distance core.
- Consumes a stream of per-candidate distances, one per accepted transfer, and tracks the minimum distance and its candidate index over a search.
- A search is delimited by in_last or by reaching K candidates.
- Presents the winning distance and index to the next stage with a valid/ready handshake. Used for nearest-neighbour matching in garbled evaluation.

Parameters:
- N, 8: bit-length of compared vectors. Distance width DW = log2(N), using the codebase log2 function (N=8 gives DW=4, range 0..8).
- K, 16: maximum candidates per search.
- IW, log2(K): index width (K=16 gives 5). Index values range 0..K-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_dist is valid this cycle.
- in_ready  output  1  block can accept a distance.
- in_dist  input  DW  distance of the current candidate (the hamming core output o).
- in_last  input  1  marks the final candidate of the search; qualified by in_valid.
- out_valid  output  1  result registers hold a completed search.
- out_ready  input  1  downstream accepts the result.
- out_min  output  DW  minimum distance of the completed search.
- out_idx  output  IW  index of the first candidate achieving out_min.
- out_ovf  output  1  search closed by reaching K candidates without in_last.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, best=0, best_idx=0, out_valid=0, out_min=0, out_idx=0, out_ovf=0. in_ready reads 1 once rst is released.
- Accept: acc = in_valid & in_ready.
- in_ready = (state != DONE). It is a registered-state decode with no combinational path from out_ready.
- State IDLE: no candidate held yet.
  - On acc: best<=in_dist, best_idx<=0, cnt<=1.
  - If in_last, or K==1: go to DONE; otherwise go to SEARCH.
- State SEARCH:
  - On acc: if in_dist < best (strict), then best<=in_dist and best_idx<=cnt. Ties keep the earlier (lower) index.
  - cnt<=cnt+1.
  - If in_last, or cnt==K-1: go to DONE.
- Entering DONE:
  - out_min and out_idx load the final best/best_idx, including the update from the closing candidate in the same cycle.
  - out_ovf <= (closing transfer had in_last==0).
  - out_valid<=1.
  - Latency: the result is visible on the cycle after the closing transfer.
- State DONE: outputs are held stable while out_valid=1 and out_ready=0.
  - When out_ready=1: out_valid<=0, cnt<=0, go to IDLE.
  - in_ready stays 0 during that handoff cycle. The next candidate can be accepted one cycle later.
- out_min, out_idx and out_ovf keep their last values after the handoff, until the next search completes.
- in_valid without in_ready is ignored. in_dist and in_last are don't-care when in_valid=0.
- Idle gaps (in_valid=0) are allowed at any point in a search. State and cnt are unchanged.
- Arithmetic:
  - The compare is unsigned, DW bits.
  - cnt is IW+1 bits wide, so there is no wrap within a search.
  - The forced close at cnt==K-1 guarantees best_idx <= K-1.
- Reset mid-search or mid-DONE discards all state immediately and returns to the reset values above.
- A distance of 0 gets no special handling; a later 0 does not replace an earlier 0.

Test Plan:
- Reset release, then candidates 5,3,7,3 with in_last on the 4th -> one cycle later out_valid=1, out_min=3, out_idx=1, out_ovf=0.
- Single candidate 6 with in_last, accepted in IDLE -> out_min=6, out_idx=0, out_ovf=0. in_ready=0 until out_ready is seen.
- 16 candidates of value 8 with no in_last, K=16 -> closes after the 16th, out_min=8, out_idx=0, out_ovf=1. A 17th in_valid is not accepted (in_ready=0).
- Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 with new data -> outputs stable, in_ready=0, nothing accepted. Then out_ready=1 -> IDLE, and the next candidate is accepted 1 cycle after the handoff.
- Gaps: candidates 4,(gap 3 cycles),2,(gap),0,in_last on 1 -> out_min=0, out_idx=2.
- Assert rst=0 asynchronously after 2 candidates (2,1) -> all outputs 0, in_ready=1 after release. A new search of 7 with in_last -> out_min=7, out_idx=0.
